// File: rtl/jtpopeye_dwnld_ctrl.sv
// Popeye ROM download sequencer: routes the ioctl byte stream into four
// on-chip ROM/PROM regions and holds the game core in reset meanwhile.
module jtpopeye_dwnld_ctrl #(
    parameter logic [21:0] CPU_END  = 22'h08000,
    parameter logic [21:0] CHAR_END = 22'h08800,
    parameter logic [21:0] OBJ_END  = 22'h10800,
    parameter logic [21:0] PROM_END = 22'h10B20,
    parameter int unsigned SETTLE   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [16:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [3:0]  prog_we,
    output logic        game_rst,
    output logic [21:0] byte_cnt,
    output logic [7:0]  csum,
    output logic        err,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN
    } state_t;

    localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);
    localparam logic [16:0] CPU_OFS   = CPU_END[16:0];
    localparam logic [16:0] CHAR_OFS  = CHAR_END[16:0];
    localparam logic [16:0] OBJ_OFS   = OBJ_END[16:0];

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] prog_addr_q, prog_addr_d;
    logic [7:0]  prog_data_q, prog_data_d;
    logic [3:0]  prog_we_q, prog_we_d;
    logic        game_rst_q, game_rst_d;
    logic [21:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        entry;
    logic        accept;
    logic        in_range;
    logic [3:0]  region;
    logic [16:0] ofs;
    logic [21:0] base_cnt;
    logic [7:0]  base_sum;
    logic        base_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_we_q   <= '0;
            game_rst_q  <= 1'b1;
            byte_cnt_q  <= '0;
            csum_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_we_q   <= prog_we_d;
            game_rst_q  <= game_rst_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (downloading) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            S_LOAD: begin
                if (!downloading) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            S_SETTLE: begin
                if (downloading) begin
                    state_d = S_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RUN: begin
                if (downloading) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // A rising download clears the stats in the same cycle its first byte lands
        entry  = downloading && (state_q != S_LOAD);
        accept = ioctl_wr && (downloading || state_q == S_LOAD);

        region = 4'b0000;
        ofs    = '0;
        unique case (1'b1)
            (ioctl_addr < CPU_END): begin
                region = 4'b0001;
                ofs    = '0;
            end
            (ioctl_addr >= CPU_END) && (ioctl_addr < CHAR_END): begin
                region = 4'b0010;
                ofs    = CPU_OFS;
            end
            (ioctl_addr >= CHAR_END) && (ioctl_addr < OBJ_END): begin
                region = 4'b0100;
                ofs    = CHAR_OFS;
            end
            (ioctl_addr >= OBJ_END) && (ioctl_addr < PROM_END): begin
                region = 4'b1000;
                ofs    = OBJ_OFS;
            end
            default: begin
                region = 4'b0000;
                ofs    = '0;
            end
        endcase
        in_range = |region;

        base_cnt = entry ? '0 : byte_cnt_q;
        base_sum = entry ? '0 : csum_q;
        base_err = entry ? 1'b0 : err_q;

        prog_we_d   = accept ? region : 4'b0000;
        prog_data_d = accept ? ioctl_data : prog_data_q;
        prog_addr_d = prog_addr_q;
        byte_cnt_d  = base_cnt;
        csum_d      = base_sum;
        err_d       = base_err;

        if (accept) begin
            if (!in_range || ioctl_addr != base_cnt) err_d = 1'b1;
            if (in_range) begin
                prog_addr_d = ioctl_addr[16:0] - ofs;
                byte_cnt_d  = base_cnt + 22'd1;
                csum_d      = base_sum + ioctl_data;
            end
        end

        done_d = entry ? 1'b0 : done_q;
        if (state_q == S_SETTLE && state_d == S_RUN) done_d = ~err_q;

        game_rst_d = (state_d != S_RUN);
    end

    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign prog_we   = prog_we_q;
    assign game_rst  = game_rst_q;
    assign byte_cnt  = byte_cnt_q;
    assign csum      = csum_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: doc/jtpopeye_dwnld_ctrl.md
Name: jtpopeye_dwnld_ctrl

Overview:
- Sequences the MiSTer ioctl ROM download stream into the Popeye on-chip ROM/PROM memories.
- Decodes each ioctl byte into one of four regions and issues a one-hot write strobe with a region-relative address.
- Holds the game core in reset during download and for a settle period afterwards, and reports byte count, checksum and error status.
- Sits between hps_io and jtpopeye_game.

Parameters:
CPU_END, 22'h08000, first address past main CPU ROM (region 0 starts at 0)
CHAR_END, 22'h08800, first address past character ROM (region 1)
OBJ_END, 22'h10800, first address past sprite ROM (region 2)
PROM_END, 22'h10B20, first address past colour/timing PROMs (region 3)
SETTLE, 16, clk cycles game reset is held after download ends (min 1)

Ports:
clk  in  1  system clock (40 MHz)
rst  in  1  asynchronous active-high reset
downloading  in  1  ioctl download active
ioctl_addr  in  22  byte address of current ioctl write
ioctl_data  in  8  byte data
ioctl_wr  in  1  single-cycle write strobe
prog_addr  out  17  region-relative byte address
prog_data  out  8  byte to write
prog_we  out  4  one-hot region write strobe, bit n = region n
game_rst  out  1  active-high reset to game core
byte_cnt  out  22  bytes accepted in current/last download
csum  out  8  mod-256 sum of accepted bytes
err  out  1  sticky: out-of-range or non-sequential address seen
done  out  1  last download completed without err

Behaviour:
- Every output is registered and clocked by clk; rst acts on all of them asynchronously.
- Reset values:
  - prog_addr=0, prog_data=0, prog_we=0
  - game_rst=1
  - byte_cnt=0, csum=0, err=0, done=0
  - FSM in IDLE
- FSM states IDLE, LOAD, SETTLE, RUN.
  - IDLE: game_rst=1. downloading=1 -> LOAD. Otherwise, after one cycle -> SETTLE.
  - Entering LOAD (from any state, whenever downloading rises): clear byte_cnt, csum, err and done; game_rst=1.
  - LOAD: accept writes as below. downloading=0 -> SETTLE and load the settle counter with SETTLE-1.
  - SETTLE: game_rst=1; counter decrements once per cycle. At 0 -> RUN, and done<=~err.
  - RUN: game_rst=0. downloading=1 -> LOAD, with game_rst reasserted in the same cycle as the transition.
- Write acceptance happens only in LOAD with ioctl_wr=1. Latency is one cycle: the strobe in cycle N gives prog_we in cycle N+1.
  - addr < CPU_END: prog_we=0001, prog_addr=addr.
  - CPU_END <= addr < CHAR_END: prog_we=0010, prog_addr=addr-CPU_END.
  - CHAR_END <= addr < OBJ_END: prog_we=0100, prog_addr=addr-CHAR_END.
  - OBJ_END <= addr < PROM_END: prog_we=1000, prog_addr=addr-OBJ_END.
  - addr >= PROM_END: prog_we=0, err<=1. The byte is not counted and not summed.
  - prog_data=ioctl_data on every accepted write.
  - prog_we is high for exactly one cycle per accepted strobe and is 0 in every other cycle.
  - Region subtraction is done at 22-bit width; prog_addr takes the low 17 bits.
- Counting rules:
  - An in-range byte increments byte_cnt (22-bit, wraps) and adds to csum (8-bit, wraps).
  - Sequence check: if ioctl_addr != byte_cnt at an accepted strobe, err<=1. The byte is still written, counted and summed.
- Boundaries and corner cases:
  - Back-to-back strobes on consecutive cycles are each processed.
  - A strobe arriving in the same cycle downloading falls is still accepted.
  - A strobe outside LOAD is ignored.
  - A strobe in the first cycle downloading is seen high is accepted, because the LOAD clear and the first byte are merged (byte_cnt=1 afterwards).
  - Exactly PROM_END-1 routes to region 3; exactly CPU_END routes to region 1 with prog_addr=0.
  - A zero-length download (downloading pulse with no strobes) -> done=1, byte_cnt=0.
  - rst asserted mid-download -> IDLE, game_rst=1, all counters cleared. With downloading still high, the FSM re-enters LOAD on the next clock.
- err and done stay sticky until the next LOAD entry or rst.

Test Plan:
- Reset then idle (downloading=0): game_rst=1 for the IDLE cycle plus 16 SETTLE cycles, then 0; done=1, byte_cnt=0, csum=0.
- Download 0x10B20 sequential bytes with data=addr[7:0]:
  - prog_we walks 0001->0010->0100->1000.
  - Address 0x08000 gives prog_we=0010, prog_addr=0.
  - Address 0x10B1F gives prog_we=1000, prog_addr=0x31F.
  - End state: byte_cnt=0x10B20, csum equals the reference sum, err=0, done=1.
  - game_rst releases exactly 16 cycles after downloading falls.
- Write to 0x10B20: prog_we stays 0, err=1, byte_cnt unchanged, and done=0 after SETTLE.
- Skip address 5 (write 0..4 then 6): err=1; byte at 6 is still written (prog_addr=6, prog_we=0001); byte_cnt=6.
- Back-to-back strobes every cycle, plus a strobe coincident with the falling edge of downloading: every byte gets a one-cycle prog_we, the count is correct, and the last byte is accepted.
- Assert rst mid-download at byte 100 while downloading stays high: all outputs return to reset values, the FSM re-enters LOAD, and a restart from addr 0 completes with err=0.
